debounce_scheduler: RTL

Multi-channel push-button cleanup controller that shares one hold-off timer among N_CH switch inputs. Each channel runs its own press/release state machine and requests the shared timer whenever it needs a debounce hold. A round-robin arbiter grants the timer to one channel at a time. The block emits one synchronous single-cycle `clean` pulse per accepted press and sits between the raw switch pins and the downstream command logic.

---
 rtl/debounce_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/debounce_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the multi-channel debounce scheduler.
package debounce_pkg;

  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_DELAY_CNT = 50000;

  // Per-channel press/release state; codes 6 and 7 are illegal and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REQ_PRESS  = 3'd1,
    ST_PRESS_HOLD = 3'd2,
    ST_WAIT_REL   = 3'd3,
    ST_REQ_REL    = 3'd4,
    ST_REL_HOLD   = 3'd5
  } ch_state_t;

  // Channel is asking for the shared timer.
  function automatic logic is_req(input ch_state_t s);
    return (s == ST_REQ_PRESS) || (s == ST_REQ_REL);
  endfunction

  // Channel currently owns the shared timer.
  function automatic logic is_hold(input ch_state_t s);
    return (s == ST_PRESS_HOLD) || (s == ST_REL_HOLD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter handing the shared hold-off timer to one requesting channel.
module rr_arbiter #(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned CH_W = $clog2(N_CH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  input  logic            en,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic [CH_W-1:0] last_grant
);

  logic found;

  // Search starts one past the previous owner so every requester is reached within N_CH grants.
  always_comb begin
    gnt     = '0;
    gnt_idx = last_grant;
    found   = 1'b0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      int unsigned cand;
      cand = 32'(last_grant) + k;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      if (en && !found && req[CH_W'(cand)]) begin
        found               = 1'b1;
        gnt[CH_W'(cand)]    = 1'b1;
        gnt_idx             = CH_W'(cand);
      end
    end
  end

  // Remember the most recent owner; reset value gives channel 0 first priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= CH_W'(N_CH - 1);
    end else if (found) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Multi-channel push-button debouncer sharing one hold-off timer via round-robin.
// Optional input synchronizer: define DEBOUNCE_SYNC_EN to add a 2-flop sync per raw bit.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter  int unsigned      N_CH      = 4,
  parameter  int unsigned      CNT_W     = DEF_CNT_W,
  parameter  logic [CNT_W-1:0] DELAY_CNT = CNT_W'(DEF_DELAY_CNT),
  localparam int unsigned      CH_W      = $clog2(N_CH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] pending,
  output logic            busy,
  output logic [CH_W-1:0] grant_idx
);

  logic [N_CH-1:0]  raw_s;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  hold;
  logic [N_CH-1:0]  req_d;
  logic [N_CH-1:0]  hold_d;
  logic [N_CH-1:0]  press_req;
  logic [N_CH-1:0]  gnt;
  logic [CH_W-1:0]  gnt_idx;
  logic [CH_W-1:0]  last_grant;
  logic [N_CH-1:0]  clean_d;
  logic [CNT_W-1:0] timer_q;
  logic             timer_done;
  logic             timer_free;
  logic             owned_q;

`ifdef DEBOUNCE_SYNC_EN
  logic [N_CH-1:0] sync_q1;
  logic [N_CH-1:0] sync_q2;

  // Two-flop synchronizer on the raw switch levels.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign raw_s = sync_q2;
`else
  assign raw_s = raw;
`endif

  assign timer_free = ~(|hold);
  assign timer_done = (timer_q == (DELAY_CNT - CNT_W'(1)));

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .en         (timer_free),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .last_grant (last_grant)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_t state_q;
    ch_state_t state_d;

    // Channel state register.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q <= ST_IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    // Press/release sequencing; raw is ignored while holding or waiting for the timer.
    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_IDLE:       if (raw_s[i])   state_d = ST_REQ_PRESS;
        ST_REQ_PRESS:  if (gnt[i])     state_d = ST_PRESS_HOLD;
        ST_PRESS_HOLD: if (timer_done) state_d = ST_WAIT_REL;
        ST_WAIT_REL:   if (!raw_s[i])  state_d = ST_REQ_REL;
        ST_REQ_REL:    if (gnt[i])     state_d = ST_REL_HOLD;
        ST_REL_HOLD:   if (timer_done) state_d = ST_IDLE;
        default:                       state_d = ST_IDLE;
      endcase
    end

    assign req[i]       = is_req(state_q);
    assign hold[i]      = is_hold(state_q);
    assign req_d[i]     = is_req(state_d);
    assign hold_d[i]    = is_hold(state_d);
    assign press_req[i] = (state_q == ST_REQ_PRESS);
  end

  // A grant to a channel waiting on a press produces its clean pulse.
  always_comb begin
    clean_d = '0;
    if ((|gnt) && press_req[gnt_idx]) begin
      clean_d[gnt_idx] = 1'b1;
    end
  end

  // Shared hold-off timer: restarts on each grant, counts while a channel holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else if (|gnt) begin
      timer_q <= '0;
    end else if (|hold) begin
      timer_q <= timer_q + CNT_W'(1);
    end
  end

  // Output registers, all derived from the next channel states.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clean   <= '0;
      pending <= '0;
      busy    <= 1'b0;
      owned_q <= 1'b0;
    end else begin
      clean   <= clean_d;
      pending <= req_d;
      busy    <= |hold_d;
      if (|gnt) begin
        owned_q <= 1'b1;
      end
    end
  end

  // Owner index reads 0 until the first grant after reset, then tracks the last owner.
  assign grant_idx = owned_q ? last_grant : '0;

endmodule
